// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, a single-entry skid
// buffer for back-pressure from IF/ID, and redirect handling with response kill.
module if_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        BUF
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            kill, kill_n;
    logic [XLEN-1:0] buf_pc, buf_pc_n;
    logic [31:0]     buf_inst, buf_inst_n;
    logic            out_valid_n;
    logic [XLEN-1:0] out_pc_n;
    logic [31:0]     out_inst_n;

    // The skid buffer holds valid data exactly while in BUF, so no separate valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REQ;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            buf_pc    <= '0;
            buf_inst  <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            kill      <= kill_n;
            buf_pc    <= buf_pc_n;
            buf_inst  <= buf_inst_n;
            out_valid <= out_valid_n;
            out_pc    <= out_pc_n;
            out_inst  <= out_inst_n;
        end
    end

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        kill_n         = kill;
        buf_pc_n       = buf_pc;
        buf_inst_n     = buf_inst;
        out_valid_n    = out_valid & hold;
        out_pc_n       = out_pc;
        out_inst_n     = out_inst;
        imem_req_valid = (state == REQ);
        imem_req_addr  = pc;

        case (state)
            REQ: begin
                // A request accepted in the same cycle as a redirect is already
                // stale, so its response must be dropped.
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (imem_req_ready) begin
                        state_n = WAIT;
                        kill_n  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_n = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (imem_resp_valid) begin
                        state_n = REQ;
                        kill_n  = 1'b0;
                    end else begin
                        kill_n  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else if (!out_valid || !hold) begin
                        out_valid_n = 1'b1;
                        out_pc_n    = pc;
                        out_inst_n  = imem_resp_data;
                        pc_n        = pc + XLEN'(4);
                        state_n     = REQ;
                    end else begin
                        buf_pc_n   = pc;
                        buf_inst_n = imem_resp_data;
                        pc_n       = pc + XLEN'(4);
                        state_n    = BUF;
                    end
                end
            end

            BUF: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = REQ;
                end else if (!hold) begin
                    out_valid_n = 1'b1;
                    out_pc_n    = buf_pc;
                    out_inst_n  = buf_inst;
                    state_n     = REQ;
                end
            end

            default: begin
                state_n = REQ;
            end
        endcase

        // Redirect squashes whatever IF/ID holds, even under hold.
        if (redirect_valid) begin
            out_valid_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; the bench drives the imem side by hand.
module tb_if_fetch;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RST_PC = 64'h0000_0000_8000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hold = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid = 1'b0;
    logic [31:0]     imem_resp_data = '0;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;

    int errors = 0;
    int checks = 0;

    if_fetch #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_pc !== '0) begin errors++; $display("[TB] FAIL rst_out_pc got %h want 0", out_pc); end
        checks++; if (out_inst !== '0) begin errors++; $display("[TB] FAIL rst_out_inst got %h want 0", out_inst); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_valid got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("[TB] FAIL rst_req_addr got %h want %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_basic_fetch();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_req_valid got %b want 0", imem_req_valid); end
        step();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        step();
        imem_resp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); end
        checks++; if (out_pc !== 64'h8000_0000) begin errors++; $display("[TB] FAIL basic_out_pc got %h want 80000000", out_pc); end
        checks++; if (out_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL basic_out_inst got %h want 00000013", out_inst); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin errors++; $display("[TB] FAIL basic_next_req got %b/%h want 1/80000004", imem_req_valid, imem_req_addr); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL consume_clear got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        hold = 1'b1;
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; step();
        imem_resp_valid = 1'b0;
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; step();
        imem_resp_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL buf_hold_out got %b/%h/%h want 1/80000000/00000013", out_valid, out_pc, out_inst); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL buf_no_req got %b want 0", imem_req_valid); end
        hold = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0004 || out_inst !== 32'h0010_0093) begin errors++; $display("[TB] FAIL buf_release got %b/%h/%h want 1/80000004/00100093", out_valid, out_pc, out_inst); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0008) begin errors++; $display("[TB] FAIL buf_next_req got %b/%h want 1/80000008", imem_req_valid, imem_req_addr); end
        step();
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; step();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_wait_stay got %b want 0", imem_req_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; step();
        imem_resp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_wait_kill got %b want 0", out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin errors++; $display("[TB] FAIL redir_wait_addr got %b/%h want 1/80000100", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_resp();
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; step();
        imem_resp_valid = 1'b0; redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_resp_drop got %b want 0", out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin errors++; $display("[TB] FAIL redir_resp_addr got %b/%h want 1/80000200", imem_req_valid, imem_req_addr); end
        // Redirect under hold must still clear out_valid.
        hold = 1'b1;
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222; step();
        imem_resp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0200) begin errors++; $display("[TB] FAIL held_deliver got %b/%h want 1/80000200", out_valid, out_pc); end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; step();
        redirect_valid = 1'b0; hold = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_hold_clear got %b want 0", out_valid); end
        checks++; if (imem_req_addr !== 64'h8000_0300) begin errors++; $display("[TB] FAIL redir_req_addr got %h want 80000300", imem_req_addr); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) begin errors++; $display("[TB] FAIL stall_req[%0d] got %b/%h want 1/80000300", i, imem_req_valid, imem_req_addr); end
        end
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_accept got %b want 0", imem_req_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333; step();
        imem_resp_valid = 1'b0;
        checks++; if (out_pc !== 64'h8000_0300 || out_inst !== 32'h3333_3333) begin errors++; $display("[TB] FAIL stall_deliver got %h/%h want 80000300/33333333", out_pc, out_inst); end
    endtask

    task automatic test_redirect_req_accept();
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0400; step();
        imem_req_ready = 1'b0; redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL req_kill_wait got %b want 0", imem_req_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h4444_4444; step();
        imem_resp_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_req_addr !== 64'h8000_0400) begin errors++; $display("[TB] FAIL req_kill_drop got %b/%h want 0/80000400", out_valid, imem_req_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555; step();
        imem_resp_valid = 1'b0;
        checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_out_pc got %h want fffffffffffffffc", out_pc); end
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("[TB] FAIL wrap_next_addr got %h want 0", imem_req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        hold = 1'b1;
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== '0 || out_inst !== '0) begin errors++; $display("[TB] FAIL async_rst_out got %b/%h/%h want 0/0/0", out_valid, out_pc, out_inst); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("[TB] FAIL async_rst_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
        hold = 1'b0;
        step(); rst_n = 1'b1; step();
        imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; step();
        imem_resp_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin errors++; $display("[TB] FAIL refetch got %b/%h want 1/%h", out_valid, out_pc, RST_PC); end
    endtask

    initial begin
        $display("[TB] if_fetch bench start");
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_redirect_wait();
        test_redirect_resp();
        test_stall();
        test_redirect_req_accept();
        test_wrap();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter XLEN, default 64, PC/address width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 hold  input  1  downstream IF/ID register stalled; current out_* not consumed.
REQ-006 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-007 redirect_pc  input  XLEN  redirect target, 4-byte aligned.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 imem_req_addr  output  XLEN  fetch address.
REQ-011 imem_resp_valid  input  1  instruction returned, 1-cycle pulse.
REQ-012 imem_resp_data  input  32  instruction word.
REQ-013 out_valid  output  1  out_pc/out_inst valid for IF/ID register.
REQ-014 out_pc  output  XLEN  PC of delivered instruction.
REQ-015 out_inst  output  32  delivered instruction.

Function
REQ-016 FSM states SHALL be REQ, WAIT, BUF; at most one request outstanding.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go to WAIT; no ready -> stay, addr stable.
REQ-018 WAIT: imem_req_valid=0; on imem_resp_valid, deliver or buffer per REQ-019/020.
REQ-019 Deliver: resp with (out_valid==0 or hold==0) -> next cycle out_valid=1, out_pc=pc, out_inst=imem_resp_data; pc<=pc+4; state REQ.
REQ-020 Buffer: resp with out_valid==1 and hold==1 -> store {pc,data} in skid buffer; pc<=pc+4; state BUF; out_* unchanged.
REQ-021 BUF: when hold==0, next cycle out_* <= buffer, out_valid=1; state REQ; while hold==1 stay BUF.
REQ-022 out_valid SHALL clear cycle after consumption (out_valid & ~hold) when no new delivery same cycle.
REQ-023 out_* SHALL stay bit-stable while out_valid & hold.
REQ-024 Fetch-to-out latency: resp cycle N -> out_valid at N+1; next request issued at N+1.
REQ-025 pc arithmetic SHALL wrap modulo 2^XLEN (all-ones-minus-3 + 4 -> 0).
REQ-026 Redirect in REQ: pc<=redirect_pc, stay REQ; request accepted same cycle is treated as WAIT-with-kill.
REQ-027 Redirect in WAIT: pc<=redirect_pc, set kill; next resp discarded (no out_valid), kill cleared, state REQ.
REQ-028 Redirect with resp same cycle: resp discarded, pc<=redirect_pc, state REQ.
REQ-029 Redirect in BUF: buffer discarded, pc<=redirect_pc, state REQ.
REQ-030 Any redirect SHALL clear out_valid next cycle regardless of hold.
REQ-031 Redirect has priority over delivery, buffering, and pc+4.

Reset
REQ-032 rst_n low SHALL immediately force: state REQ, pc=RESET_PC, kill=0, buffer invalid, out_valid=0, out_pc=0, out_inst=0.
REQ-033 imem_req_valid asserts in first cycle after rst_n deasserts, addr=RESET_PC.
REQ-034 Reset mid-WAIT abandons request; memory resets on same rst_n, no stale response expected.

Verification
REQ-035 Reset release, ready=1, resp 2 cycles later with 32'h00000013 -> out_valid=1, out_pc=8000_0000, out_inst=0000_0013; next addr 8000_0004.
REQ-036 Delivered insn with hold=1, second resp 32'h00100093 arrives -> state BUF, out unchanged; hold drops -> out_pc=8000_0004, out_inst=0010_0093.
REQ-037 Redirect to 8000_0100 in WAIT -> pending resp dropped, no out_valid, next req addr 8000_0100.
REQ-038 redirect_valid and imem_resp_valid same cycle -> no out_valid, next addr=redirect_pc.
REQ-039 ready=0 for 5 cycles -> imem_req_valid=1, addr stable throughout, single acceptance.
REQ-040 rst_n pulsed low mid-WAIT -> outputs zero immediately, refetch from 8000_0000.
